led_crossfade_pwm: RTL and testbench

//   Downstream LED output stage for the 12 MHz board. Accepts "light LED n" requests from
//   the sequencing logic and drives the four red LEDs (pin_d1..pin_d4) with PWM.

---
 rtl/led_crossfade_pwm.sv | 87 ++++++++
 tb/tb_led_crossfade_pwm.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/led_crossfade_pwm.sv
// Four-channel red LED PWM driver with linear crossfade between the active LED and a
// newly requested one; the green LED (pin_d5) marks a fade in progress.
module led_crossfade_pwm #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 11719
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sel,
  input  logic       sel_valid,
  output logic       sel_ready,
  output logic       pin_d1,
  output logic       pin_d2,
  output logic       pin_d3,
  output logic       pin_d4,
  output logic       pin_d5
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(STEP_DIV - 1);
  localparam logic [PWM_BITS:0] FULL      = {1'b1, {PWM_BITS{1'b0}}};

  typedef enum logic {IDLE, FADE} state_t;

  state_t              state;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PW-1:0]       presc;
  logic                tick;
  logic [1:0]          cur;
  logic [1:0]          tgt;
  logic [PWM_BITS:0]   duty [4];
  logic [3:0]          pins;

  assign tick      = (presc == PRESC_MAX);
  assign sel_ready = (state == IDLE);
  assign {pin_d4, pin_d3, pin_d2, pin_d1} = pins;

  // NOTE: sequential state uses non-blocking assignments only, so every read below sees
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pwm_cnt <= '0;
      presc   <= '0;
      cur     <= 2'd0;
      tgt     <= 2'd0;
      pins    <= '0;
      pin_d5  <= 1'b0;
      // NOTE: the duty array is reset like ordinary flops because its reset contents
      // (LED0 full, others dark) are visible behaviour, not don't-care storage.
      duty[0] <= FULL;
      duty[1] <= '0;
      duty[2] <= '0;
      duty[3] <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      presc   <= tick ? '0 : presc + 1'b1;
      for (int i = 0; i < 4; i++) begin
        pins[i] <= ({1'b0, pwm_cnt} < duty[i]);
      end
      pin_d5 <= (state == FADE);

      case (state)
        IDLE: begin
          // A request for the LED already lit is accepted and dropped.
          if (sel_valid && sel != cur) begin
            tgt   <= sel;
            state <= FADE;
          end
        end
        FADE: begin
          if (tick) begin
            if (duty[cur] != '0)  duty[cur] <= duty[cur] - 1'b1;
            if (duty[tgt] != FULL) duty[tgt] <= duty[tgt] + 1'b1;
            // Outgoing LED hits zero on this step: incoming one is full at the same time.
            if (duty[cur] <= 1) begin
              cur   <= tgt;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_crossfade_pwm.sv
// Self-checking bench for led_crossfade_pwm (PWM_BITS=3, STEP_DIV=4): table-driven fades,
// hand-written corner sequences and random requests against a cycle-count reference model.
module tb_led_crossfade_pwm;

  localparam int PWM_BITS = 3;
  localparam int STEP_DIV = 4;
  localparam int FULL     = 1 << PWM_BITS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       sel_valid = 1'b0;
  logic       sel_ready;
  logic       pin_d1, pin_d2, pin_d3, pin_d4, pin_d5;
  logic [3:0] pins;

  assign pins = {pin_d4, pin_d3, pin_d2, pin_d1};

  led_crossfade_pwm #(.PWM_BITS(PWM_BITS), .STEP_DIV(STEP_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .pin_d1(pin_d1), .pin_d2(pin_d2), .pin_d3(pin_d3), .pin_d4(pin_d4), .pin_d5(pin_d5)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: time is counted in clock edges since reset release; the PWM phase
  // and the step ticks follow from that count by plain modulo arithmetic.
  int         m_cyc;
  int         m_duty [4];
  int         m_cur, m_tgt;
  bit         m_fading;
  logic [3:0] exp_pins;
  logic       exp_d5;

  task automatic model_reset();
    m_cyc    = 0;
    m_duty   = '{FULL, 0, 0, 0};
    m_cur    = 0;
    m_tgt    = 0;
    m_fading = 0;
    exp_pins = '0;
    exp_d5   = 1'b0;
  endtask

  task automatic model_step();
    int  phase;
    bit  step;
    phase = m_cyc % FULL;
    step  = (m_cyc % STEP_DIV) == STEP_DIV - 1;
    for (int i = 0; i < 4; i++) exp_pins[i] = (phase < m_duty[i]);
    exp_d5 = m_fading;
    if (!m_fading) begin
      if (sel_valid && int'(sel) != m_cur) begin
        m_tgt    = int'(sel);
        m_fading = 1;
      end
    end else if (step) begin
      m_duty[m_cur] = (m_duty[m_cur] > 0)    ? m_duty[m_cur] - 1 : 0;
      m_duty[m_tgt] = (m_duty[m_tgt] < FULL) ? m_duty[m_tgt] + 1 : FULL;
      if (m_duty[m_cur] == 0) begin
        m_cur    = m_tgt;
        m_fading = 0;
      end
    end
    m_cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("pins", 32'(pins), 32'(exp_pins));
    check("pin_d5", 32'(pin_d5), 32'(exp_d5));
    check("sel_ready", 32'(sel_ready), 32'(!m_fading));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    sel_valid = 1'b0;
    #1;
    check("reset_pins", 32'({pin_d5, pins}), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    check("reset_hold_pins", 32'({pin_d5, pins}), 32'h0);
    check("reset_ready", 32'(sel_ready), 32'h1);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Watch a full PWM period and require exactly the given LED to be steadily lit.
  task automatic check_steady(input string name, input logic [1:0] led);
    logic [3:0] on_and, on_or;
    on_and = '1;
    on_or  = '0;
    repeat (FULL) begin
      cycle();
      on_and &= pins;
      on_or  |= pins;
    end
    check({name, "_always_on"}, 32'(on_and), 32'(4'b1 << led));
    check({name, "_ever_on"}, 32'(on_or), 32'(4'b1 << led));
    check({name, "_ready"}, 32'(sel_ready), 32'h1);
    check({name, "_green"}, 32'(pin_d5), 32'h0);
  endtask

  task automatic pulse(input logic [1:0] s);
    sel       = s;
    sel_valid = 1'b1;
    cycle();
    sel_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0] sel;
    int         wait_cycles;
    logic [1:0] exp_led;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int         ready_cnt;
    bit         accepted;
    logic [3:0] seen;

    vecs[0] = '{sel: 2'd2, wait_cycles: 40, exp_led: 2'd2};  // fade 0 -> 2
    vecs[1] = '{sel: 2'd2, wait_cycles: 6,  exp_led: 2'd2};  // same LED: no-op
    vecs[2] = '{sel: 2'd3, wait_cycles: 40, exp_led: 2'd3};
    vecs[3] = '{sel: 2'd0, wait_cycles: 40, exp_led: 2'd0};
    vecs[4] = '{sel: 2'd1, wait_cycles: 40, exp_led: 2'd1};

    do_reset();
    check_steady("after_reset", 2'd0);

    for (int v = 0; v < 5; v++) begin
      pulse(vecs[v].sel);
      repeat (vecs[v].wait_cycles) cycle();
      check_steady($sformatf("vec%0d", v), vecs[v].exp_led);
    end

    // Request arriving mid-fade is dropped; LED1 must never light.
    do_reset();
    pulse(2'd2);
    repeat (10) cycle();
    pulse(2'd1);
    seen = '0;
    repeat (40) begin
      cycle();
      seen |= pins;
    end
    check("ignored_req_d2_dark", 32'(seen[1]), 32'h0);
    check_steady("ignored_req", 2'd2);

    // Reset during a fade drops the request and restores LED0.
    do_reset();
    pulse(2'd3);
    repeat (13) cycle();
    do_reset();
    repeat (4) cycle();
    check_steady("mid_fade_reset", 2'd0);

    // Held request is taken on the single ready cycle between back-to-back fades.
    do_reset();
    pulse(2'd3);
    sel       = 2'd1;
    sel_valid = 1'b1;
    ready_cnt = 0;
    accepted  = 0;
    for (int i = 0; i < 60 && !accepted; i++) begin
      if (sel_ready) ready_cnt++;
      cycle();
      accepted = m_fading && m_tgt == 1;
    end
    sel_valid = 1'b0;
    check("held_req_accepted", 32'(accepted), 32'h1);
    check("held_req_ready_cycles", 32'(ready_cnt), 32'h1);
    repeat (40) cycle();
    check_steady("back_to_back", 2'd1);

    // Random requests against the model.
    for (int i = 0; i < 600; i++) begin
      sel       = 2'($urandom_range(0, 3));
      sel_valid = ($urandom_range(0, 7) == 0);
      cycle();
    end
    sel_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
